// File: rtl/rv32v_types_pkg.sv
// Shared vector-unit types for the rv32v execute stage.
//   vsew_t        : element width encoding (SEW64 and above run as SEW32 in the divider)
//   vdiv_input_t  : request bundle driven by the execute lane into vdiv_lane_unit
//   vdiv_output_t : response bundle {vd_res, vdiv_busy}
//   vdiv_state_t  : divider lane FSM states
// Helper functions decode SEW into an element bit count and mask, and build the
// RVV special-case results.
package rv32v_types_pkg;

  typedef enum logic [2:0] {
    SEW8  = 3'd0,
    SEW16 = 3'd1,
    SEW32 = 3'd2,
    SEW64 = 3'd3
  } vsew_t;

  typedef struct packed {
    logic        vdiv_en;
    logic [31:0] vs1_data;       // divisor
    logic [31:0] vs2_data;       // dividend
    vsew_t       vsew;
    logic        vdivremainder;  // 1: remainder, 0: quotient
    logic        vopunsigned;
    logic        vmem_use_stall;
    logic        flush;
  } vdiv_input_t;

  typedef struct packed {
    logic [31:0] vd_res;
    logic        vdiv_busy;
  } vdiv_output_t;

  typedef enum logic [1:0] {
    VDIV_IDLE,
    VDIV_CALC,
    VDIV_DONE
  } vdiv_state_t;

  // Element width in bits; wider encodings fall back to 32.
  function automatic int unsigned sew_bits(vsew_t sew);
    case (sew)
      SEW8:    return 8;
      SEW16:   return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] sew_mask(vsew_t sew);
    case (sew)
      SEW8:    return 32'h0000_00ff;
      SEW16:   return 32'h0000_ffff;
      default: return 32'hffff_ffff;
    endcase
  endfunction

  // Results that bypass the iterative loop. Operands are already masked to the element.
  // Priority: divide-by-zero, then signed overflow, then |dividend| < |divisor|.
  function automatic logic [31:0] special_res(logic rem_op, logic div0, logic ovf,
                                              logic [31:0] dvd, logic [31:0] mask);
    if (div0) return rem_op ? dvd : mask;
    if (ovf)  return rem_op ? 32'h0 : dvd;
    return rem_op ? dvd : 32'h0;
  endfunction

endpackage

// File: rtl/vdiv_step.sv
// One restoring-division step (combinational).
//   rem          : current partial remainder (always < divisor)
//   divisor      : divisor magnitude
//   dividend_bit : next dividend bit, MSB first
//   rem_next     : updated partial remainder
//   q_bit        : quotient bit produced by this step
module vdiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividend_bit,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = (shifted >= {1'b0, divisor});
    // Either branch fits in XLEN bits because the result is below the divisor.
    rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/vdiv_lane_unit.sv
// Per-lane vector integer divider (VDIV/VDIVU/VREM/VREMU) for one SEW element per request.
// Radix-2 restoring loop on operand magnitudes; sign fixup applied on exit.
//   CLK      : clock
//   nRST     : asynchronous active-low reset
//   vdiv_in  : request bundle {vdiv_en, vs1_data, vs2_data, vsew, vdivremainder,
//              vopunsigned, vmem_use_stall, flush}
//   vdiv_out : {vd_res, vdiv_busy}
// Build option: define VDIV_FAST_SPECIAL_EN to let divide-by-zero, signed overflow and
// |dividend| < |divisor| skip the loop (DONE on the cycle after accept). Results are
// identical either way.
module vdiv_lane_unit
  import rv32v_types_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_WIDTH = 6
) (
  input  logic         CLK,
  input  logic         nRST,
  input  vdiv_input_t  vdiv_in,
  output vdiv_output_t vdiv_out
);

  vdiv_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]      dvd_q, dvd_d;    // dividend magnitude, MSB-aligned shift register
  logic [XLEN-1:0]      dvs_q, dvs_d;    // divisor magnitude
  logic [XLEN-1:0]      rem_q, rem_d;    // partial remainder
  logic [XLEN-1:0]      quo_q, quo_d;    // quotient bits shifted in from the LSB
  logic [XLEN-1:0]      mask_q, mask_d;
  logic [XLEN-1:0]      raw_q, raw_d;    // masked signed dividend, for special results
  logic                 rem_op_q, rem_op_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div0_q, div0_d;
  logic                 ovf_q, ovf_d;
  logic [XLEN-1:0]      res_q, res_d;
  logic                 busy;

  // Request decode
  logic [CNT_WIDTH-1:0] n_in;
  logic [XLEN-1:0]      mask_in, msb_in, a_in, b_in, a_mag, b_mag;
  logic                 signed_in, sign_a, sign_b, div0_in, ovf_in;

  always_comb begin
    n_in      = CNT_WIDTH'(sew_bits(vdiv_in.vsew));
    mask_in   = sew_mask(vdiv_in.vsew);
    msb_in    = mask_in ^ (mask_in >> 1);
    a_in      = vdiv_in.vs2_data & mask_in;
    b_in      = vdiv_in.vs1_data & mask_in;
    signed_in = ~vdiv_in.vopunsigned;
    sign_a    = signed_in & (|(a_in & msb_in));
    sign_b    = signed_in & (|(b_in & msb_in));
    a_mag     = sign_a ? ((-a_in) & mask_in) : a_in;
    b_mag     = sign_b ? ((-b_in) & mask_in) : b_in;
    div0_in   = (b_in == '0);
    ovf_in    = signed_in & (a_in == msb_in) & (b_in == mask_in);
  end

`ifdef VDIV_FAST_SPECIAL_EN
  logic small_in;
  assign small_in = (a_mag < b_mag);
`endif

  // Datapath step
  logic [XLEN-1:0] step_rem;
  logic            step_q;

  vdiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem         (rem_q),
    .divisor     (dvs_q),
    .dividend_bit(dvd_q[XLEN-1]),
    .rem_next    (step_rem),
    .q_bit       (step_q)
  );

  // The quotient never exceeds N <= XLEN bits, so the top register bit falls off.
  logic quo_msb_unused;
  assign quo_msb_unused = quo_q[XLEN-1];

  logic [XLEN-1:0] q_fin, quo_fix, rem_fix, calc_res;

  always_comb begin
    q_fin    = {quo_q[XLEN-2:0], step_q};
    quo_fix  = neg_quo_q ? ((-q_fin) & mask_q) : (q_fin & mask_q);
    rem_fix  = neg_rem_q ? ((-step_rem) & mask_q) : (step_rem & mask_q);
    calc_res = (div0_q | ovf_q) ? special_res(rem_op_q, div0_q, ovf_q, raw_q, mask_q)
                                : (rem_op_q ? rem_fix : quo_fix);
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    mask_d    = mask_q;
    raw_d     = raw_q;
    rem_op_d  = rem_op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    busy      = 1'b0;

    unique case (state_q)
      VDIV_IDLE: begin
        busy = vdiv_in.vdiv_en & ~vdiv_in.flush;
        if (vdiv_in.vdiv_en && !vdiv_in.flush) begin
          cnt_d     = n_in;
          dvd_d     = a_mag << (CNT_WIDTH'(XLEN) - n_in);
          dvs_d     = b_mag;
          rem_d     = '0;
          quo_d     = '0;
          mask_d    = mask_in;
          raw_d     = a_in;
          rem_op_d  = vdiv_in.vdivremainder;
          neg_quo_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          div0_d    = div0_in;
          ovf_d     = ovf_in;
          state_d   = VDIV_CALC;
`ifdef VDIV_FAST_SPECIAL_EN
          if (div0_in || ovf_in || small_in) begin
            res_d   = special_res(vdiv_in.vdivremainder, div0_in, ovf_in, a_in, mask_in);
            state_d = VDIV_DONE;
          end
`endif
        end
      end

      VDIV_CALC: begin
        busy  = 1'b1;
        cnt_d = cnt_q - 1'b1;
        dvd_d = dvd_q << 1;
        rem_d = step_rem;
        quo_d = q_fin;
        if (cnt_q == CNT_WIDTH'(1)) begin
          res_d   = calc_res;
          state_d = VDIV_DONE;
        end
      end

      VDIV_DONE: begin
        // A pending memory stall keeps the result presented; new requests wait.
        if (!vdiv_in.vmem_use_stall) state_d = VDIV_IDLE;
      end

      default: state_d = VDIV_IDLE;
    endcase

    if (vdiv_in.flush) begin
      state_d = VDIV_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= VDIV_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      mask_q    <= '0;
      raw_q     <= '0;
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      mask_q    <= mask_d;
      raw_q     <= raw_d;
      rem_op_q  <= rem_op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
    end
  end

  always_comb begin
    vdiv_out.vd_res    = res_q;
    vdiv_out.vdiv_busy = busy;
  end

endmodule

// File: tb/tb_vdiv_lane_unit.sv
// Directed bench for vdiv_lane_unit: hand-computed quotients/remainders, busy lengths,
// stall hold, flush and asynchronous reset behaviour.
module tb_vdiv_lane_unit;
  import rv32v_types_pkg::*;

`ifdef VDIV_FAST_SPECIAL_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic         CLK;
  logic         nRST;
  vdiv_input_t  vdiv_in;
  vdiv_output_t vdiv_out;

  int checks = 0;
  int errors = 0;

  vdiv_lane_unit dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .vdiv_in (vdiv_in),
    .vdiv_out(vdiv_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request, count busy cycles (including the accept cycle), check result and
  // latency, then step past DONE back to IDLE.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input vsew_t sew, input logic rem, input logic uns,
                        input logic [31:0] exp_res, input int exp_cycles);
    int cycles;
    vdiv_in.vs2_data      = a;
    vdiv_in.vs1_data      = b;
    vdiv_in.vsew          = sew;
    vdiv_in.vdivremainder = rem;
    vdiv_in.vopunsigned   = uns;
    vdiv_in.vdiv_en       = 1'b1;
    #1;
    cycles = 0;
    while (vdiv_out.vdiv_busy && cycles < 200) begin
      cycles++;
      tick();
      // Operands are latched; scribbling on them must not matter.
      vdiv_in.vdiv_en  = 1'b0;
      vdiv_in.vs2_data = 32'hdead_beef;
      vdiv_in.vs1_data = 32'h0bad_f00d;
      #1;
    end
    check({tag, " busy cycles"}, 32'(cycles), 32'(exp_cycles));
    check({tag, " vd_res"}, vdiv_out.vd_res, exp_res);
    if (!vdiv_in.vmem_use_stall) tick();
  endtask

  initial begin
    vdiv_in = '0;
    vdiv_in.vsew = SEW32;
    nRST = 1'b0;
    #1;
    check("reset vd_res", vdiv_out.vd_res, 32'h0);
    check("reset busy", 32'(vdiv_out.vdiv_busy), 32'h0);
    tick();
    tick();
    nRST = 1'b1;
    tick();

    // Test 1: SEW32 unsigned
    run_op("divu32 100/7", 32'd100, 32'd7, SEW32, 1'b0, 1'b1, 32'd14, 33);
    run_op("remu32 100/7", 32'd100, 32'd7, SEW32, 1'b1, 1'b1, 32'd2, 33);

    // Test 2: SEW8 signed, upper operand bits ignored
    run_op("div8 -7/2", 32'habcd_eff9, 32'h1234_5602, SEW8, 1'b0, 1'b0, 32'h0000_00fd, 9);
    run_op("rem8 -7/2", 32'h0000_00f9, 32'h0000_0002, SEW8, 1'b1, 1'b0, 32'h0000_00ff, 9);
    run_op("divu8 249/2", 32'h0000_00f9, 32'h0000_0002, SEW8, 1'b0, 1'b1, 32'h0000_007c, 9);
    run_op("remu8 249/2", 32'h0000_00f9, 32'h0000_0002, SEW8, 1'b1, 1'b1, 32'h0000_0001, 9);

    // Test 3: divide by zero
    run_op("divu16 by 0", 32'h0000_1234, 32'h0, SEW16, 1'b0, 1'b1, 32'h0000_ffff,
           Fast ? 1 : 17);
    run_op("remu16 by 0", 32'h0000_1234, 32'h0, SEW16, 1'b1, 1'b1, 32'h0000_1234,
           Fast ? 1 : 17);
    run_op("div16 neg by 0", 32'h0000_8001, 32'hffff_0000, SEW16, 1'b0, 1'b0, 32'h0000_ffff,
           Fast ? 1 : 17);
    run_op("rem16 neg by 0", 32'h0000_8001, 32'h0, SEW16, 1'b1, 1'b0, 32'h0000_8001,
           Fast ? 1 : 17);

    // Test 4: signed overflow
    run_op("div32 ovf", 32'h8000_0000, 32'hffff_ffff, SEW32, 1'b0, 1'b0, 32'h8000_0000,
           Fast ? 1 : 33);
    run_op("rem32 ovf", 32'h8000_0000, 32'hffff_ffff, SEW32, 1'b1, 1'b0, 32'h0, Fast ? 1 : 33);
    run_op("div8 ovf", 32'h0000_0080, 32'h0000_00ff, SEW8, 1'b0, 1'b0, 32'h0000_0080,
           Fast ? 1 : 9);

    // Mixed signs, small-dividend cases, SEW64 fallback
    run_op("div16 7/-2", 32'h0000_0007, 32'h0000_fffe, SEW16, 1'b0, 1'b0, 32'h0000_fffd, 17);
    run_op("rem16 7/-2", 32'h0000_0007, 32'h0000_fffe, SEW16, 1'b1, 1'b0, 32'h0000_0001, 17);
    run_op("divu32 5/9", 32'd5, 32'd9, SEW32, 1'b0, 1'b1, 32'd0, Fast ? 1 : 33);
    run_op("rem8 -3/5", 32'h0000_00fd, 32'h0000_0005, SEW8, 1'b1, 1'b0, 32'h0000_00fd,
           Fast ? 1 : 9);
    run_op("divu sew64", 32'd1000, 32'd10, SEW64, 1'b0, 1'b1, 32'd100, 33);

    // Test 5: stall holds DONE
    vdiv_in.vmem_use_stall = 1'b1;
    run_op("stall op", 32'd100, 32'd7, SEW32, 1'b0, 1'b1, 32'd14, 33);
    vdiv_in.vs2_data = 32'd50;
    vdiv_in.vs1_data = 32'd5;
    vdiv_in.vdiv_en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall busy", 32'(vdiv_out.vdiv_busy), 32'h0);
      check("stall vd_res", vdiv_out.vd_res, 32'd14);
    end
    vdiv_in.vdiv_en        = 1'b0;
    vdiv_in.vmem_use_stall = 1'b0;
    tick();
    check("post-stall idle", 32'(vdiv_out.vdiv_busy), 32'h0);
    run_op("after stall 50/5", 32'd50, 32'd5, SEW32, 1'b0, 1'b1, 32'd10, 33);

    // Test 6: flush mid-CALC
    vdiv_in.vs2_data = 32'd1000;
    vdiv_in.vs1_data = 32'd3;
    vdiv_in.vdivremainder = 1'b0;
    vdiv_in.vdiv_en  = 1'b1;
    tick();  // accepted; CALC cycle 1
    vdiv_in.vdiv_en = 1'b0;
    tick();
    tick();
    tick();  // CALC cycle 4
    check("calc busy", 32'(vdiv_out.vdiv_busy), 32'h1);
    vdiv_in.flush = 1'b1;
    tick();
    vdiv_in.flush = 1'b0;
    #1;
    check("flush busy", 32'(vdiv_out.vdiv_busy), 32'h0);
    check("flush vd_res", vdiv_out.vd_res, 32'd10);
    tick();
    check("flush stays idle", 32'(vdiv_out.vdiv_busy), 32'h0);

    // flush together with vdiv_en in IDLE: nothing starts
    vdiv_in.vdiv_en = 1'b1;
    vdiv_in.flush   = 1'b1;
    tick();
    vdiv_in.vdiv_en = 1'b0;
    vdiv_in.flush   = 1'b0;
    #1;
    check("flush+en no start", 32'(vdiv_out.vdiv_busy), 32'h0);
    check("flush+en vd_res", vdiv_out.vd_res, 32'd10);

    // Async reset mid-CALC
    vdiv_in.vdiv_en = 1'b1;
    tick();
    vdiv_in.vdiv_en = 1'b0;
    tick();
    tick();
    #2;
    nRST = 1'b0;
    #1;
    check("async rst vd_res", vdiv_out.vd_res, 32'h0);
    check("async rst busy", 32'(vdiv_out.vdiv_busy), 32'h0);
    tick();
    nRST = 1'b1;
    tick();
    run_op("after rst divu16", 32'h0000_1234, 32'h0000_0010, SEW16, 1'b0, 1'b1,
           32'h0000_0123, 17);
    run_op("after rst remu16", 32'h0000_1234, 32'h0000_0010, SEW16, 1'b1, 1'b1,
           32'h0000_0004, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
